// File: rtl/uart_rx_dma_pkg.sv
// Shared types and constants for the UART receive-to-ring DMA controller.
package uart_rx_dma_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS,
        ST_STATUS_GAP,
        ST_DATA,
        ST_DATA_GAP,
        ST_WRITE,
        ST_FULL,
        ST_POLL_WAIT
    } state_e;

    // UART register map and status layout.
    localparam logic [1:0] ADDR_DATA        = 2'd0;
    localparam logic [1:0] ADDR_STATUS      = 2'd1;
    localparam int         STATUS_EMPTY_BIT = 1;

    // Ring entry layout: three data bytes, oldest in the low byte, count on top.
    localparam int         ENTRY_BYTE0_LSB  = 0;
    localparam int         ENTRY_BYTE1_LSB  = 8;
    localparam int         ENTRY_BYTE2_LSB  = 16;
    localparam int         ENTRY_COUNT_LSB  = 24;
    localparam logic [1:0] BYTES_PER_ENTRY  = 2'd3;

    // Build a ring entry from the byte store and its valid count.
    function automatic logic [31:0] pack_entry(input logic [2:0][7:0] bytes,
                                               input logic [1:0]      count);
        logic [31:0] entry;
        entry = '0;
        entry[ENTRY_BYTE0_LSB +: 8] = bytes[0];
        entry[ENTRY_BYTE1_LSB +: 8] = bytes[1];
        entry[ENTRY_BYTE2_LSB +: 8] = bytes[2];
        entry[ENTRY_COUNT_LSB +: 8] = {6'b0, count};
        return entry;
    endfunction

endpackage

// File: rtl/uart_rx_dma_ring.sv
// Producer side of the word ring: write index with wrap bit and full detect.
module uart_rx_dma_ring
    import uart_rx_dma_pkg::*;
#(
    parameter int RING_WORDS = 64
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_advance,
    input  logic [$clog2(RING_WORDS):0] i_rd_index,
    output logic [$clog2(RING_WORDS):0] o_wr_index,
    output logic                        o_full
);

    // Indices match in the low bits but differ in the wrap bit when full.
    localparam logic [$clog2(RING_WORDS):0] FULL_XOR = {1'b1, {$clog2(RING_WORDS){1'b0}}};

    logic [$clog2(RING_WORDS):0] r_wr_index;

    // Advance the write index once per accepted memory write; the natural
    // width wrap gives modulo 2*RING_WORDS.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_index <= '0;
        end else if (i_advance) begin
            r_wr_index <= r_wr_index + 1'b1;
        end
    end

    assign o_wr_index = r_wr_index;
    assign o_full     = (r_wr_index ^ i_rd_index) == FULL_XOR;

endmodule

// File: rtl/uart_rx_dma.sv
// Polls the UART receiver, packs received bytes three per word and writes
// each word into a software-owned ring buffer in system memory.
module uart_rx_dma
    import uart_rx_dma_pkg::*;
#(
    parameter int RING_WORDS   = 64,
    parameter int FLUSH_CYCLES = 1024,
    parameter int POLL_GAP     = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic [31:0]                 i_base,
    input  logic [$clog2(RING_WORDS):0] i_rd_index,
    output logic [$clog2(RING_WORDS):0] o_wr_index,
    output logic                        o_full,
    output logic                        o_interrupt,
    output logic                        o_uart_request,
    output logic [1:0]                  o_uart_address,
    input  logic [31:0]                 i_uart_rdata,
    input  logic                        i_uart_ready,
    output logic                        o_mem_request,
    output logic                        o_mem_rw,
    output logic [31:0]                 o_mem_address,
    output logic [31:0]                 o_mem_wdata,
    input  logic                        i_mem_ready
);

    localparam int IDX_W = $clog2(RING_WORDS) + 1;
    localparam int TMR_W = $clog2(FLUSH_CYCLES + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [TMR_W-1:0] FLUSH_LIMIT = TMR_W'(FLUSH_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(POLL_GAP - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [1:0]        r_pending;
    logic [2:0][7:0]   r_bytes;
    logic              r_empty;
    logic [TMR_W-1:0]  r_timer;
    logic [GAP_W-1:0]  r_gap_cnt;

    logic              r_uart_request;
    logic [1:0]        r_uart_address;
    logic              r_mem_request;
    logic [31:0]       r_mem_address;
    logic [31:0]       r_mem_wdata;
    logic              r_full;
    logic              r_interrupt;

    logic [IDX_W-1:0]  w_wr_index;
    logic              w_ring_full;
    logic              w_uart_done;
    logic              w_mem_done;
    logic              w_advance;
    logic [31:0]       w_entry_address;
    logic              w_unused_bits;

    assign w_uart_done     = r_uart_request & i_uart_ready;
    assign w_mem_done      = r_mem_request & i_mem_ready;
    assign w_advance       = (r_state == ST_WRITE) & w_mem_done;
    assign w_entry_address = {i_base[31:2], 2'b00} + (32'(w_wr_index[IDX_W-2:0]) << 2);
    assign w_unused_bits   = ^{i_uart_rdata[31:8], i_base[1:0]};

    uart_rx_dma_ring #(
        .RING_WORDS (RING_WORDS)
    ) u_ring (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_advance  (w_advance),
        .i_rd_index (i_rd_index),
        .o_wr_index (w_wr_index),
        .o_full     (w_ring_full)
    );

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment ahead of the case covers every path, so
    // no latch is inferred for states that simply hold.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable)               w_state_next = ST_STATUS;
                else if (r_pending != 2'd0) w_state_next = ST_WRITE;
            end
            ST_STATUS: begin
                if (w_uart_done) w_state_next = ST_STATUS_GAP;
            end
            ST_STATUS_GAP: begin
                if (!r_empty)
                    w_state_next = ST_DATA;
                else if (r_pending != 2'd0 && r_timer >= FLUSH_LIMIT)
                    w_state_next = ST_WRITE;
                else
                    w_state_next = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (r_gap_cnt == GAP_LAST) w_state_next = ST_IDLE;
            end
            ST_DATA: begin
                if (w_uart_done) w_state_next = ST_DATA_GAP;
            end
            ST_DATA_GAP: begin
                w_state_next = (r_pending == BYTES_PER_ENTRY) ? ST_WRITE : ST_STATUS;
            end
            ST_WRITE: begin
                // A write already on the bus is always allowed to finish.
                if (w_ring_full && !r_mem_request) w_state_next = ST_FULL;
                else if (w_mem_done)                w_state_next = ST_IDLE;
            end
            ST_FULL: begin
                if (!w_ring_full) w_state_next = ST_WRITE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Registered bus outputs, derived from the state being entered.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_uart_request <= 1'b0;
            r_uart_address <= ADDR_DATA;
            r_mem_request  <= 1'b0;
            r_mem_address  <= '0;
            r_mem_wdata    <= '0;
            r_full         <= 1'b0;
            r_interrupt    <= 1'b0;
        end else begin
            r_uart_request <= (w_state_next == ST_STATUS) || (w_state_next == ST_DATA);
            if (w_state_next == ST_STATUS) r_uart_address <= ADDR_STATUS;
            if (w_state_next == ST_DATA)   r_uart_address <= ADDR_DATA;
            r_mem_request  <= (w_state_next == ST_WRITE) && !w_ring_full;
            // Address and data freeze once the request is up.
            if (w_state_next == ST_WRITE && !r_mem_request) begin
                r_mem_address <= w_entry_address;
                r_mem_wdata   <= pack_entry(r_bytes, r_pending);
            end
            r_full         <= (w_state_next == ST_FULL);
            r_interrupt    <= w_advance;
        end
    end

    // Byte packing, status capture, flush timer and poll gap counter.
    // NOTE: the byte store is reset and cleared after every write so the
    // unused slots of a partial entry are guaranteed to read as zero.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pending <= 2'd0;
            r_bytes   <= '0;
            r_empty   <= 1'b1;
            r_timer   <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (r_state == ST_STATUS && w_uart_done) begin
                r_empty <= i_uart_rdata[STATUS_EMPTY_BIT];
            end

            if (r_state == ST_DATA && w_uart_done) begin
                r_bytes[r_pending] <= i_uart_rdata[7:0];
                r_pending          <= r_pending + 2'd1;
                r_timer            <= '0;
            end else if (w_advance) begin
                r_pending <= 2'd0;
                r_bytes   <= '0;
                r_timer   <= '0;
            end else if (r_pending != 2'd0 && r_state != ST_DATA && r_timer < FLUSH_LIMIT) begin
                r_timer <= r_timer + 1'b1;
            end

            r_gap_cnt <= (r_state == ST_POLL_WAIT) ? r_gap_cnt + 1'b1 : '0;
        end
    end

    assign o_wr_index     = w_wr_index;
    assign o_full         = r_full;
    assign o_interrupt    = r_interrupt;
    assign o_uart_request = r_uart_request;
    assign o_uart_address = r_uart_address;
    assign o_mem_request  = r_mem_request;
    assign o_mem_rw       = 1'b1;
    assign o_mem_address  = r_mem_address;
    assign o_mem_wdata    = r_mem_wdata;

endmodule
